// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants, FSM state type and size decode
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_CAPT,
    ST_RESP
  } lsu_state_e;

  // Byte mask of an access of the size encoded in funct3[1:0], before lane shift.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Loads accept LB/LH/LW/LBU/LHU, stores only SB/SH/SW.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        F3_SB, F3_SH, F3_SW: return 1'b1;
        default:             return 1'b0;
      endcase
    end
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// rtl/lsu_access_ctrl_if.sv - core request/response bundle and RAM port bundle
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 10);
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byteen;
  logic              mem_wren;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_addr, mem_byteen, mem_wren, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_byteen, mem_wren, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane mask, store data shift and load merge/extend
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [7:0]  lane_mask,
  output logic [63:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [5:0]  shamt;
  logic [31:0] raw;

  assign shamt     = {off, 3'b000};
  assign lane_mask = {4'b0000, size_mask(funct3[1:0])} << off;
  assign wdata_sh  = {32'b0, wdata} << shamt;
  assign raw       = 32'({rdata_hi, rdata_lo} >> shamt);

  // Extend the right-justified load value according to access type.
  always_comb begin
    rdata_ext = raw;
    case (funct3)
      F3_LB:   rdata_ext = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   rdata_ext = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  rdata_ext = {24'b0, raw[7:0]};
      F3_LHU:  rdata_ext = {16'b0, raw[15:0]};
      default: rdata_ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// rtl/lsu_access_ctrl.sv - load/store sequencer for a 1-cycle-latency byte-enabled RAM
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  lsu_state_e        state, state_nx;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_word0;
  logic [31:0]       r_wdata;
  logic [31:0]       cap_lo;

  logic              accept;
  logic              legal;
  logic              split;
  logic [7:0]        lane_mask;
  logic [63:0]       wdata_sh;
  logic [31:0]       rd_lo, rd_hi, rd_ext;

  assign core.req_ready = (state == ST_IDLE);
  assign accept         = core.req_valid && core.req_ready;
  assign legal          = funct3_legal(core.req_we, core.req_funct3);
  assign split          = |lane_mask[7:4];

  // In CAPT the live RAM data is word0 for an aligned access and word1 for a split one.
  assign rd_lo = split ? cap_lo : mem.mem_rdata;
  assign rd_hi = split ? mem.mem_rdata : 32'b0;

  lsu_lane_align u_align (
    .funct3    (r_f3),
    .off       (r_off),
    .wdata     (r_wdata),
    .rdata_lo  (rd_lo),
    .rdata_hi  (rd_hi),
    .lane_mask (lane_mask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rd_ext)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state and RAM drive; RAM outputs are decoded from state so reset silences them at once.
  always_comb begin
    state_nx       = state;
    mem.mem_addr   = '0;
    mem.mem_byteen = 4'b0000;
    mem.mem_wren   = 1'b0;
    mem.mem_wdata  = 32'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = legal ? ST_ACC0 : ST_RESP;
      end
      ST_ACC0: begin
        mem.mem_addr   = r_word0;
        mem.mem_byteen = lane_mask[3:0];
        mem.mem_wren   = r_we;
        mem.mem_wdata  = wdata_sh[31:0];
        if (split)     state_nx = ST_ACC1;
        else if (r_we) state_nx = ST_RESP;
        else           state_nx = ST_CAPT;
      end
      ST_ACC1: begin
        mem.mem_addr   = r_word0 + 1'b1;
        mem.mem_byteen = lane_mask[7:4];
        mem.mem_wren   = r_we;
        mem.mem_wdata  = wdata_sh[63:32];
        state_nx       = r_we ? ST_RESP : ST_CAPT;
      end
      ST_CAPT: state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request fields are held for the whole access; address bits above the RAM are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_word0 <= '0;
      r_wdata <= 32'b0;
    end else if (accept) begin
      r_we    <= core.req_we;
      r_f3    <= core.req_funct3;
      r_off   <= core.req_addr[1:0];
      r_word0 <= core.req_addr[ADDR_W+1:2];
      r_wdata <= core.req_wdata;
    end
  end

  // Word0 of a split load arrives during ACC1 and must be held until word1 arrives in CAPT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              cap_lo <= 32'b0;
    else if (state == ST_ACC1) cap_lo <= mem.mem_rdata;
  end

  // Response registers: set on entry to RESP, cleared on leaving it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core.resp_valid <= 1'b0;
      core.resp_err   <= 1'b0;
      core.resp_rdata <= 32'b0;
    end else begin
      core.resp_valid <= (state_nx == ST_RESP);
      core.resp_err   <= accept && !legal;
      core.resp_rdata <= (state == ST_CAPT) ? rd_ext : 32'b0;
    end
  end

endmodule
